p_shfrot_issue: RTL and testbench

Pipelined issue front end for packed shift/rotate operations. Accepts encoded requests from the core's execute stage over a valid/ready handshake, decodes the pack width and operation, and normalises the shift amount. It drives a combinational packed shifter and returns registered results over a second valid/ready handshake. It sits between the XCrypto instruction decoder and the writeback arbiter. It is the control and initiator side of the packed shifter's input interface.

---
 rtl/p_shfrot_pkg.sv | 34 +++
 rtl/p_shfrot.sv | 79 +++++++
 rtl/p_shfrot_issue.sv | 176 +++++++++++++++++
 tb/tb_p_shfrot_issue.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_shfrot_pkg.sv
// Shared encodings and helpers for the packed shift/rotate issue front end.
package p_shfrot_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROL = 2'b10,
        OP_ROR = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        PW_32 = 3'd0,
        PW_16 = 3'd1,
        PW_8  = 3'd2,
        PW_4  = 3'd3,
        PW_2  = 3'd4
    } pw_e;

    // Any pack-width code at or above this value is illegal.
    localparam logic [2:0] PW_ILLEGAL = 3'd5;

    // Element width in bits for a pack-width code; 0 for illegal codes.
    function automatic logic [5:0] pw_width(input logic [2:0] pw);
        case (pw)
            PW_32:   pw_width = 6'd32;
            PW_16:   pw_width = 6'd16;
            PW_8:    pw_width = 6'd8;
            PW_4:    pw_width = 6'd4;
            PW_2:    pw_width = 6'd2;
            default: pw_width = 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/p_shfrot.sv
// Combinational packed shifter. Each element of the selected width is
// shifted or rotated independently; the amount arrives already normalised
// (shifts saturate at the element width, rotates are reduced modulo it).
module p_shfrot
    import p_shfrot_pkg::*;
(
    input  logic [31:0] crs1,
    input  logic [4:0]  shamt,
    input  logic        pw_32,
    input  logic        pw_16,
    input  logic        pw_8,
    input  logic        pw_4,
    input  logic        pw_2,
    input  logic        shift,
    input  logic        rotate,
    input  logic        left,
    input  logic        right,
    output logic [31:0] result
);

    // Bit-level packed operation for one fixed element width w.
    // A shift amount equal to w clears the element.
    function automatic logic [31:0] packed_op(
        input logic [31:0] x,
        input int          w,
        input int          a,
        input logic        sl,
        input logic        sr,
        input logic        rl,
        input logic        rr
    );
        logic [31:0] r;
        int          off;
        int          base;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            off  = i & (w - 1);
            base = i - off;
            if (sl && (off >= a)) begin
                r[i] = x[5'(i - a)];
            end else if (sr && ((off + a) < w)) begin
                r[i] = x[5'(i + a)];
            end else if (rl) begin
                r[i] = x[5'(base + ((off + w - a) & (w - 1)))];
            end else if (rr) begin
                r[i] = x[5'(base + ((off + a) & (w - 1)))];
            end
        end
        return r;
    endfunction

    logic sl;
    logic sr;
    logic rl;
    logic rr;
    int   amt_i;

    // Select the element width from the one-hot pack width and apply the op.
    always_comb begin
        sl     = shift & left;
        sr     = shift & right;
        rl     = rotate & left;
        rr     = rotate & right;
        amt_i  = int'(shamt);
        result = '0;
        if (pw_32) begin
            result = packed_op(crs1, 32, amt_i, sl, sr, rl, rr);
        end else if (pw_16) begin
            result = packed_op(crs1, 16, amt_i, sl, sr, rl, rr);
        end else if (pw_8) begin
            result = packed_op(crs1, 8, amt_i, sl, sr, rl, rr);
        end else if (pw_4) begin
            result = packed_op(crs1, 4, amt_i, sl, sr, rl, rr);
        end else if (pw_2) begin
            result = packed_op(crs1, 2, amt_i, sl, sr, rl, rr);
        end
    end

endmodule

// File: rtl/p_shfrot_issue.sv
// Two-stage issue front end for the packed shifter: S1 holds the decoded
// request, S2 holds the registered result presented on the response port.
module p_shfrot_issue
    import p_shfrot_pkg::*;
(
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_pw,
    input  logic        req_imm,
    input  logic [4:0]  req_shamt,
    input  logic [31:0] req_crs1,
    input  logic [31:0] req_crs2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_error,
    output logic        busy
);

    logic        s1_valid_q,  s1_valid_d;
    logic [4:0]  s1_pw_oh_q,  s1_pw_oh_d;
    logic        s1_shift_q,  s1_shift_d;
    logic        s1_rotate_q, s1_rotate_d;
    logic        s1_left_q,   s1_left_d;
    logic        s1_right_q,  s1_right_d;
    logic [4:0]  s1_amt_q,    s1_amt_d;
    logic [31:0] s1_crs1_q,   s1_crs1_d;
    logic        s1_err_q,    s1_err_d;
    logic        s2_valid_q,  s2_valid_d;
    logic [31:0] s2_result_q, s2_result_d;
    logic        s2_err_q,    s2_err_d;

    logic        s2_free;
    logic        s1_adv;
    logic        accept;
    logic [4:0]  raw_amt;
    logic [5:0]  width;
    logic [4:0]  wmask;
    logic        dec_err;
    logic        dec_rotate;
    logic        dec_left;
    logic [4:0]  dec_pw_oh;
    logic [4:0]  dec_amt;
    logic [31:0] shf_result;
    logic        crs2_unused;

    // Only the low five bits of crs2 form a shift amount.
    assign crs2_unused = ^req_crs2[31:5];

    // Handshake: S1 drains into S2 whenever S2 is empty or being consumed.
    always_comb begin
        s2_free   = !s2_valid_q | rsp_ready;
        s1_adv    = s1_valid_q & s2_free;
        req_ready = !s1_valid_q | s1_adv;
        accept    = req_valid & req_ready;
    end

    // Decode the incoming request and normalise its amount to the element width.
    always_comb begin
        raw_amt    = req_imm ? req_shamt : req_crs2[4:0];
        width      = pw_width(req_pw);
        wmask      = 5'(width - 6'd1);
        dec_err    = (req_pw >= PW_ILLEGAL);
        dec_rotate = (req_op == OP_ROL) | (req_op == OP_ROR);
        dec_left   = (req_op == OP_SLL) | (req_op == OP_ROL);
        dec_pw_oh  = {req_pw == PW_2, req_pw == PW_4, req_pw == PW_8,
                      req_pw == PW_16, req_pw == PW_32};
        dec_amt    = raw_amt;
        if (dec_err) begin
            dec_amt = '0;
        end else if (dec_rotate) begin
            dec_amt = raw_amt & wmask;
        end else if ({1'b0, raw_amt} >= width) begin
            dec_amt = 5'(width);
        end
    end

    p_shfrot u_shfrot (
        .crs1   (s1_crs1_q),
        .shamt  (s1_amt_q),
        .pw_32  (s1_pw_oh_q[0]),
        .pw_16  (s1_pw_oh_q[1]),
        .pw_8   (s1_pw_oh_q[2]),
        .pw_4   (s1_pw_oh_q[3]),
        .pw_2   (s1_pw_oh_q[4]),
        .shift  (s1_shift_q),
        .rotate (s1_rotate_q),
        .left   (s1_left_q),
        .right  (s1_right_q),
        .result (shf_result)
    );

    // Next-state for both stages; flush kills every valid bit.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_pw_oh_d  = s1_pw_oh_q;
        s1_shift_d  = s1_shift_q;
        s1_rotate_d = s1_rotate_q;
        s1_left_d   = s1_left_q;
        s1_right_d  = s1_right_q;
        s1_amt_d    = s1_amt_q;
        s1_crs1_d   = s1_crs1_q;
        s1_err_d    = s1_err_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_err_d    = s2_err_q;

        if (accept) begin
            s1_valid_d  = 1'b1;
            s1_pw_oh_d  = dec_pw_oh;
            s1_shift_d  = !dec_rotate;
            s1_rotate_d = dec_rotate;
            s1_left_d   = dec_left;
            s1_right_d  = !dec_left;
            s1_amt_d    = dec_amt;
            s1_crs1_d   = req_crs1;
            s1_err_d    = dec_err;
        end else if (s1_adv) begin
            s1_valid_d  = 1'b0;
        end

        if (s1_adv) begin
            s2_valid_d  = 1'b1;
            s2_result_d = s1_err_q ? 32'd0 : shf_result;
            s2_err_d    = s1_err_q;
        end else if (rsp_ready) begin
            s2_valid_d  = 1'b0;
        end

        if (flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            s1_valid_q  <= 1'b0;
            s1_pw_oh_q  <= '0;
            s1_shift_q  <= 1'b0;
            s1_rotate_q <= 1'b0;
            s1_left_q   <= 1'b0;
            s1_right_q  <= 1'b0;
            s1_amt_q    <= '0;
            s1_crs1_q   <= '0;
            s1_err_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_err_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_pw_oh_q  <= s1_pw_oh_d;
            s1_shift_q  <= s1_shift_d;
            s1_rotate_q <= s1_rotate_d;
            s1_left_q   <= s1_left_d;
            s1_right_q  <= s1_right_d;
            s1_amt_q    <= s1_amt_d;
            s1_crs1_q   <= s1_crs1_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_err_q    <= s2_err_d;
        end
    end

    assign rsp_valid  = s2_valid_q;
    assign rsp_result = s2_result_q;
    assign rsp_error  = s2_err_q;
    assign busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_p_shfrot_issue.sv
// Self-checking bench for p_shfrot_issue: an element-arithmetic reference
// model feeds an in-order scoreboard checked every cycle, plus directed
// literal checks for reset, latency, backpressure, flush and reset-kill.
module tb_p_shfrot_issue;
    import p_shfrot_pkg::*;

    logic        g_clk;
    logic        g_resetn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [2:0]  req_pw;
    logic        req_imm;
    logic [4:0]  req_shamt;
    logic [31:0] req_crs1;
    logic [31:0] req_crs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          age;
    } exp_t;

    exp_t model_q[$];
    bit   armed = 0;
    bit   exp_v;
    bit   exp_rdy;
    bit   stim_done;

    p_shfrot_issue dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_pw     (req_pw),
        .req_imm    (req_imm),
        .req_shamt  (req_shamt),
        .req_crs1   (req_crs1),
        .req_crs2   (req_crs2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .busy       (busy)
    );

    // Free-running clock.
    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Reference: split the word into elements and apply the op arithmetically.
    function automatic logic [31:0] model_calc(input logic [1:0] op, input logic [2:0] pw,
                                               input logic [4:0] amt, input logic [31:0] x);
        int              w;
        int              a;
        int              n;
        longint unsigned mask;
        longint unsigned v;
        longint unsigned r;
        logic [31:0]     res;
        res = '0;
        if (pw > 3'd4) return res;
        w    = 32 >> pw;
        n    = int'(amt);
        mask = (64'd1 << w) - 64'd1;
        for (int e = 0; e < 32 / w; e++) begin
            v = ({32'd0, x} >> (e * w)) & mask;
            r = 0;
            case (op)
                2'b00: r = (n >= w) ? 64'd0 : ((v << n) & mask);
                2'b01: r = (n >= w) ? 64'd0 : (v >> n);
                2'b10: begin a = n % w; r = ((v << a) | (v >> (w - a))) & mask; end
                default: begin a = n % w; r = ((v >> a) | (v << (w - a))) & mask; end
            endcase
            res = res | 32'(r << (e * w));
        end
        return res;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Offer one request and hold it until accepted (bounded wait).
    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] pw, input logic imm,
                                 input logic [4:0] shamt, input logic [31:0] c1, input logic [31:0] c2);
        bit acc;
        int n;
        req_valid = 1'b1;
        req_op    = op;
        req_pw    = pw;
        req_imm   = imm;
        req_shamt = shamt;
        req_crs1  = c1;
        req_crs2  = c2;
        acc = 0;
        n   = 0;
        while (!acc && n < 60) begin
            @(negedge g_clk);
            acc = req_ready;
            @(posedge g_clk);
            #1;
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: request never accepted after %0d cycles", n);
        end
        req_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(posedge g_clk);
            #1;
            n++;
        end
        checkOutput("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    // Scoreboard: compare outputs mid-cycle, then advance the model for the next edge.
    always @(negedge g_clk) begin
        exp_v   = (model_q.size() > 0) && (model_q[0].age >= 2);
        exp_rdy = (model_q.size() < 2) || (rsp_ready == 1'b1);
        if (armed) begin
            checkOutput("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_v});
            checkOutput("busy", {31'd0, busy}, {31'd0, model_q.size() > 0});
            checkOutput("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
            if (exp_v) begin
                checkOutput("rsp_result", rsp_result, model_q[0].res);
                checkOutput("rsp_error", {31'd0, rsp_error}, {31'd0, model_q[0].err});
            end
        end
        if (!g_resetn || flush) begin
            model_q.delete();
        end else if (armed) begin
            if (exp_v && rsp_ready) void'(model_q.pop_front());
            foreach (model_q[i]) model_q[i].age++;
            if (req_valid && exp_rdy) begin
                exp_t t;
                t.err = (req_pw >= 3'd5);
                t.res = t.err ? 32'd0 :
                        model_calc(req_op, req_pw, req_imm ? req_shamt : req_crs2[4:0], req_crs1);
                t.age = 1;
                model_q.push_back(t);
            end
        end
        if (!g_resetn) armed = 1;
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        g_resetn  = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_pw    = 3'd0;
        req_imm   = 1'b0;
        req_shamt = 5'd0;
        req_crs1  = 32'd0;
        req_crs2  = 32'd0;
        rsp_ready = 1'b1;

        // Pin the reference model on hand-computed vectors.
        checkOutput("model_sll32", model_calc(OP_SLL, 3'd0, 5'd4, 32'h0000_0001), 32'h0000_0010);
        checkOutput("model_rol8", model_calc(OP_ROL, 3'd2, 5'd1, 32'h8142_1801), 32'h0384_3002);
        checkOutput("model_ror4", model_calc(OP_ROR, 3'd3, 5'd19, 32'h1234_5678), 32'h2468_ACE1);
        checkOutput("model_srl16", model_calc(OP_SRL, 3'd1, 5'd17, 32'hFFFF_FFFF), 32'h0000_0000);
        checkOutput("model_sll2", model_calc(OP_SLL, 3'd4, 5'd1, 32'h5555_5555), 32'hAAAA_AAAA);
        checkOutput("model_rol0", model_calc(OP_ROL, 3'd0, 5'd0, 32'hCAFE_F00D), 32'hCAFE_F00D);

        repeat (3) @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        @(negedge g_clk);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_result", rsp_result, 32'd0);
        checkOutput("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge g_clk);
        #1;

        // Latency of a single sll: visible two cycles after accept.
        applyStimulus(OP_SLL, 3'd0, 1'b1, 5'd4, 32'h0000_0001, 32'd0);
        @(negedge g_clk);
        checkOutput("lat_s1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge g_clk);
        #1;
        @(negedge g_clk);
        checkOutput("lat_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        checkOutput("lat_rsp_result", rsp_result, 32'h0000_0010);
        checkOutput("lat_rsp_error", {31'd0, rsp_error}, 32'd0);
        @(posedge g_clk);
        #1;

        // Test-plan vectors back to back, with an illegal width between legal ops.
        applyStimulus(OP_ROL, 3'd2, 1'b1, 5'd1, 32'h8142_1801, 32'd0);
        applyStimulus(OP_ROR, 3'd3, 1'b0, 5'd0, 32'h1234_5678, 32'h0000_0013);
        applyStimulus(OP_SRL, 3'd1, 1'b1, 5'd17, 32'hFFFF_FFFF, 32'd0);
        applyStimulus(OP_SLL, 3'd4, 1'b1, 5'd1, 32'h5555_5555, 32'd0);
        applyStimulus(OP_SLL, 3'd0, 1'b1, 5'd4, 32'h0000_0001, 32'd0);
        applyStimulus(OP_ROL, 3'd6, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        applyStimulus(OP_ROL, 3'd2, 1'b1, 5'd1, 32'h8142_1801, 32'd0);
        waitIdle();

        // Backpressure: three requests with rsp_ready low stall after two.
        rsp_ready = 1'b0;
        fork
            begin
                applyStimulus(OP_SLL, 3'd0, 1'b1, 5'd4, 32'h0000_0001, 32'd0);
                applyStimulus(OP_ROL, 3'd2, 1'b1, 5'd1, 32'h8142_1801, 32'd0);
                applyStimulus(OP_ROR, 3'd3, 1'b0, 5'd0, 32'h1234_5678, 32'h0000_0013);
            end
            begin
                repeat (4) begin
                    @(posedge g_clk);
                    #1;
                end
                @(negedge g_clk);
                checkOutput("bp_req_ready", {31'd0, req_ready}, 32'd0);
                checkOutput("bp_hold_result", rsp_result, 32'h0000_0010);
                @(posedge g_clk);
                #1;
                rsp_ready = 1'b1;
            end
        join
        waitIdle();

        // Flush with a full pipeline and a request presented in the same cycle.
        rsp_ready = 1'b0;
        applyStimulus(OP_SRL, 3'd1, 1'b1, 5'd3, 32'hF0F0_1234, 32'd0);
        applyStimulus(OP_ROR, 3'd0, 1'b1, 5'd8, 32'h89AB_CDEF, 32'd0);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_op    = OP_SLL;
        req_pw    = 3'd2;
        req_shamt = 5'd2;
        req_crs1  = 32'h1111_1111;
        @(posedge g_clk);
        #1;
        flush     = 1'b0;
        req_valid = 1'b0;
        @(negedge g_clk);
        checkOutput("flush_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("flush_busy", {31'd0, busy}, 32'd0);
        repeat (4) begin
            @(posedge g_clk);
            #1;
        end
        applyStimulus(OP_SLL, 3'd3, 1'b0, 5'd0, 32'h1234_5678, 32'h0000_0021);
        waitIdle();

        // Reset mid-operation (with flush also high) discards the entry.
        applyStimulus(OP_ROL, 3'd1, 1'b1, 5'd5, 32'hABCD_0123, 32'd0);
        g_resetn = 1'b0;
        flush    = 1'b1;
        @(posedge g_clk);
        #1;
        g_resetn = 1'b1;
        flush    = 1'b0;
        @(negedge g_clk);
        checkOutput("midreset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        @(posedge g_clk);
        #1;

        // Sweep every op and width code with toggling rsp_ready.
        stim_done = 0;
        fork
            begin
                for (int i = 0; i < 32; i++) begin
                    logic [4:0] amt_v;
                    amt_v = 5'((i * 7) % 32);
                    applyStimulus(2'(i % 4), 3'(i / 4), 1'(i % 2), amt_v,
                                  32'h9E37_79B9 ^ (32'h0101_0101 * 32'(i)), 32'(i * 5));
                end
                stim_done = 1;
            end
            begin
                int k;
                k = 0;
                while (!stim_done && k < 1000) begin
                    @(posedge g_clk);
                    #1;
                    rsp_ready = ((k % 3) != 2);
                    k++;
                end
            end
        join
        rsp_ready = 1'b1;
        waitIdle();

        repeat (2) @(posedge g_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
